// File: rtl/qam_upconverter.sv
// qam_upconverter: FIFO-buffered I/Q transmit back end. Each baseband sample is
// released for UPS sample slots (held or zero-stuffed) and mixed onto an fs/4
// carrier by 4-phase rotation, with saturating negation.
module qam_upconverter #(
    parameter int DW         = 18,
    parameter int FIFO_DEPTH = 8,
    parameter int UPS        = 4,
    parameter int ZERO_STUFF = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sam_clk_ena,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DW-1:0]                 in_i,
    input  logic [DW-1:0]                 in_q,
    input  logic [1:0]                    mode,
    input  logic                          clear_flags,
    output logic [DW-1:0]                 tx_out,
    output logic                          out_valid,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (UPS > 1) ? $clog2(UPS) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(UPS - 1);
    localparam logic [DW-1:0] MOST_NEG  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MOST_POS  = {1'b0, {(DW-1){1'b1}}};

    // FIFO storage: I in the upper half, Q in the lower half
    logic [2*DW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [2*DW-1:0] head;
    logic            full;
    logic            empty;
    logic            push;
    logic            fetch;

    // Stage-1 state
    logic [SW-1:0]   slot;
    logic [1:0]      ph;
    logic [1:0]      ph_cur;
    logic [DW-1:0]   hold_i;
    logic [DW-1:0]   hold_q;
    logic            zero_slot;
    logic            strobe_d;

    // Stage-2 mixer
    logic [DW-1:0]   sel_i;
    logic [DW-1:0]   sel_q;
    logic [DW-1:0]   mix;

    function automatic logic [DW-1:0] sat_neg(input logic [DW-1:0] x);
        if (x == MOST_NEG)
            return MOST_POS;
        else
            return -x;
    endfunction

    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
    assign empty      = (wr_ptr == rd_ptr);
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign fetch      = sam_clk_ena && (slot == '0);
    assign head       = mem[rd_ptr[AW-1:0]];

    // FIFO write port (storage needs no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {in_i, in_q};
    end

    // Stage 1: pointers, slot/phase counters, hold registers, underflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            slot      <= '0;
            ph        <= '0;
            ph_cur    <= '0;
            hold_i    <= '0;
            hold_q    <= '0;
            zero_slot <= 1'b0;
            strobe_d  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            strobe_d <= sam_clk_ena;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (sam_clk_ena) begin
                slot      <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
                ph_cur    <= ph;
                ph        <= ph + 2'd1;
                zero_slot <= (ZERO_STUFF != 0) && (slot != '0);
            end
            if (fetch) begin
                if (empty) begin
                    hold_i <= '0;
                    hold_q <= '0;
                end else begin
                    hold_i <= head[2*DW-1:DW];
                    hold_q <= head[DW-1:0];
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            // A new underflow takes priority over a clear in the same cycle
            if (fetch && empty)
                underflow <= 1'b1;
            else if (clear_flags)
                underflow <= 1'b0;
        end
    end

    // 4-phase fs/4 rotation with mode selection; mode is sampled here
    always_comb begin
        sel_i = zero_slot ? '0 : hold_i;
        sel_q = zero_slot ? '0 : hold_q;
        mix   = '0;
        case (mode)
            2'd0: begin
                case (ph_cur)
                    2'd0:    mix = sel_q;
                    2'd1:    mix = sel_i;
                    2'd2:    mix = sat_neg(sel_q);
                    default: mix = sat_neg(sel_i);
                endcase
            end
            2'd1: begin
                case (ph_cur)
                    2'd0:    mix = sel_q;
                    2'd1:    mix = sat_neg(sel_i);
                    2'd2:    mix = sat_neg(sel_q);
                    default: mix = sel_i;
                endcase
            end
            2'd2:    mix = sel_i;
            default: mix = '0;
        endcase
    end

    // Stage 2: register the mixed sample one cycle after each strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_out    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= strobe_d;
            if (strobe_d)
                tx_out <= mix;
        end
    end

endmodule

// File: tb/tb_qam_upconverter.sv
// Directed bench for qam_upconverter: fs/4 rotation, modes, zero stuffing,
// saturation, FIFO fill/wrap, underflow and asynchronous reset.
module tb_qam_upconverter;

    localparam int DW = 18;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 sam_clk_ena = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_ready_zs;
    logic signed [DW-1:0] in_i = '0;
    logic signed [DW-1:0] in_q = '0;
    logic [1:0]           mode = 2'd0;
    logic                 clear_flags = 1'b0;
    logic signed [DW-1:0] tx_out;
    logic signed [DW-1:0] tx_out_zs;
    logic                 out_valid;
    logic                 out_valid_zs;
    logic                 underflow;
    logic                 underflow_zs;
    logic [3:0]           fifo_level;
    logic [3:0]           fifo_level_zs;

    int total = 0;
    int bad = 0;
    int ov_total = 0;

    qam_upconverter #(.DW(DW), .FIFO_DEPTH(8), .UPS(4), .ZERO_STUFF(0)) dut (
        .clk(clk), .reset(reset), .sam_clk_ena(sam_clk_ena),
        .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
        .mode(mode), .clear_flags(clear_flags), .tx_out(tx_out),
        .out_valid(out_valid), .underflow(underflow), .fifo_level(fifo_level)
    );

    qam_upconverter #(.DW(DW), .FIFO_DEPTH(8), .UPS(4), .ZERO_STUFF(1)) dut_zs (
        .clk(clk), .reset(reset), .sam_clk_ena(sam_clk_ena),
        .in_valid(in_valid), .in_ready(in_ready_zs), .in_i(in_i), .in_q(in_q),
        .mode(mode), .clear_flags(clear_flags), .tx_out(tx_out_zs),
        .out_valid(out_valid_zs), .underflow(underflow_zs), .fifo_level(fifo_level_zs)
    );

    always #5 clk = ~clk;

    // Count out_valid pulses of the main instance
    always @(negedge clk) begin
        if (out_valid)
            ov_total <= ov_total + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input int vi, input int vq);
        @(negedge clk);
        in_valid = 1'b1;
        in_i = DW'(vi);
        in_q = DW'(vq);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // One sample-rate strobe, four clocks long; returns the resulting output
    task automatic strobe(output int v, output int vz);
        @(negedge clk);
        sam_clk_ena = 1'b1;
        @(negedge clk);
        sam_clk_ena = 1'b0;
        @(negedge clk);
        v  = int'(tx_out);
        vz = int'(tx_out_zs);
        @(negedge clk);
    endtask

    int v, vz, base, nxt;
    int exp0 [8] = '{200, 100, -200, -100, -7, 5, 7, -5};
    int exps [4] = '{-131072, -131072, 131071, 131071};

    initial begin
        // Reset state
        #12;
        chk("rst_tx_out", int'(tx_out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_underflow", int'(underflow), 0);
        @(negedge clk);
        reset = 1'b1;

        // Mode 0, hold: two samples over eight strobes
        mode = 2'd0;
        push(100, 200);
        push(5, -7);
        chk("m0_level2", int'(fifo_level), 2);
        base = ov_total;
        for (int k = 0; k < 8; k++) begin
            strobe(v, vz);
            chk($sformatf("m0_out%0d", k), v, exp0[k]);
        end
        chk("m0_ov_count", ov_total - base, 8);
        chk("m0_no_underflow", int'(underflow), 0);
        strobe(v, vz);
        chk("starve_underflow", int'(underflow), 1);
        chk("starve_tx_zero", v, 0);
        strobe(v, vz);
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("clear_underflow", int'(underflow), 0);

        // Mode 1, then switch to mode 2 mid-sample
        do_reset();
        mode = 2'd1;
        push(100, 200);
        strobe(v, vz); chk("m1_ph0", v, 200);
        strobe(v, vz); chk("m1_ph1", v, -100);
        mode = 2'd2;
        strobe(v, vz); chk("m2_ph2", v, 100);
        strobe(v, vz); chk("m2_ph3", v, 100);
        mode = 2'd0;
        push(3, 9);
        strobe(v, vz); chk("ph_kept_ph0", v, 9);
        strobe(v, vz); chk("ph_kept_ph1", v, 3);
        mode = 2'd3;
        strobe(v, vz); chk("m3_mute", v, 0);
        strobe(v, vz);

        // Zero stuffing versus hold
        do_reset();
        mode = 2'd0;
        push(1000, 1000);
        strobe(v, vz); chk("zs_s0", vz, 1000); chk("hold_s0", v, 1000);
        strobe(v, vz); chk("zs_s1", vz, 0);    chk("hold_s1", v, 1000);
        strobe(v, vz); chk("zs_s2", vz, 0);    chk("hold_s2", v, -1000);
        strobe(v, vz); chk("zs_s3", vz, 0);    chk("hold_s3", v, -1000);

        // Saturating negation
        do_reset();
        push(-131072, -131072);
        for (int k = 0; k < 4; k++) begin
            strobe(v, vz);
            chk($sformatf("sat_out%0d", k), v, exps[k]);
        end

        // FIFO fill with no strobes, then pop/push and drain across the wrap
        do_reset();
        nxt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_i = DW'(nxt);
            in_q = DW'(nxt + 50);
            if (in_ready)
                nxt++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("fill_accepts", nxt, 8);
        chk("fill_in_ready", int'(in_ready), 0);
        chk("fill_level", int'(fifo_level), 8);
        @(negedge clk);
        sam_clk_ena = 1'b1;
        in_valid = 1'b1;
        in_i = DW'(8);
        in_q = DW'(58);
        @(negedge clk);
        sam_clk_ena = 1'b0;
        chk("pop_in_ready", int'(in_ready), 1);
        chk("pop_level", int'(fifo_level), 7);
        @(negedge clk);
        in_valid = 1'b0;
        chk("refill_level", int'(fifo_level), 8);
        chk("refill_tx", int'(tx_out), 50);
        @(negedge clk);
        for (int s = 0; s < 3; s++)
            strobe(v, vz);
        for (int k = 1; k <= 8; k++) begin
            strobe(v, vz);
            chk($sformatf("order_q%0d", k), v, k + 50);
            strobe(v, vz);
            chk($sformatf("order_i%0d", k), v, k);
            strobe(v, vz);
            strobe(v, vz);
        end
        chk("drain_level", int'(fifo_level), 0);
        chk("drain_no_underflow", int'(underflow), 0);

        // Asynchronous reset mid-stream
        push(7, 11);
        strobe(v, vz);
        chk("pre_rst_tx", v, 11);
        push(1, 2);
        push(3, 4);
        @(negedge clk);
        sam_clk_ena = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_tx_out", int'(tx_out), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_level", int'(fifo_level), 0);
        chk("arst_underflow", int'(underflow), 0);
        @(negedge clk);
        sam_clk_ena = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_level", int'(fifo_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
